// File: rtl/spi_rx.sv
// SPI slave byte receiver: oversamples CS/SCK/SDI/DC in the 125 MHz domain,
// assembles MSB-first bytes tagged with D/C into a small show-ahead FIFO.
module spi_rx #(
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk_125mhz,
   input  logic                     reset,
   input  logic                     spi_cs_n,
   input  logic                     spi_sck,
   input  logic                     spi_sdi,
   input  logic                     spi_dc,
   input  logic                     rd,
   input  logic                     clr,
   output logic [8:0]               rdata,
   output logic                     empty,
   output logic                     full,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     overflow,
   output logic                     frame_err
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam int unsigned DW = 9;
   localparam int unsigned BW = 3;

   localparam logic [1:0] S_SYNC  = 2'd0;
   localparam logic [1:0] S_IDLE  = 2'd1;
   localparam logic [1:0] S_SHIFT = 2'd2;
   localparam logic [1:0] S_HOLD  = 2'd3;

   logic          r_cs_meta, r_cs_s, r_cs_d;
   logic          r_sck_meta, r_sck_s, r_sck_d;
   logic          r_sdi_meta, r_sdi_s;
   logic          r_dc_meta, r_dc_s;
   logic [1:0]    r_settle;
   logic [1:0]    r_state, w_state_nxt;
   logic [BW-1:0] r_bitcnt, w_bitcnt_nxt;
   logic [6:0]    r_shreg, w_shreg_nxt;
   logic          w_push, w_ferr_set;
   logic [DW-1:0] w_push_data;

   logic [DW-1:0] r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr, r_rd_ptr;
   logic [CW-1:0] r_count;
   logic          r_overflow, r_frame_err;
   logic          w_full, w_empty, w_do_pop, w_do_push, w_ovf_set;

   logic          w_sck_rise, w_cs_fall, w_cs_rise;

   // Two-flop synchronizers plus a delay stage on cs_n/sck for edge detection
   always_ff @(posedge clk_125mhz or posedge reset) begin
      if (reset) begin
         r_cs_meta  <= 1'b1;
         r_cs_s     <= 1'b1;
         r_cs_d     <= 1'b1;
         r_sck_meta <= 1'b1;
         r_sck_s    <= 1'b1;
         r_sck_d    <= 1'b1;
         r_sdi_meta <= 1'b0;
         r_sdi_s    <= 1'b0;
         r_dc_meta  <= 1'b0;
         r_dc_s     <= 1'b0;
      end else begin
         r_cs_meta  <= spi_cs_n;
         r_cs_s     <= r_cs_meta;
         r_cs_d     <= r_cs_s;
         r_sck_meta <= spi_sck;
         r_sck_s    <= r_sck_meta;
         r_sck_d    <= r_sck_s;
         r_sdi_meta <= spi_sdi;
         r_sdi_s    <= r_sdi_meta;
         r_dc_meta  <= spi_dc;
         r_dc_s     <= r_dc_meta;
      end
   end

   assign w_sck_rise  = r_sck_s & ~r_sck_d;
   assign w_cs_fall   = ~r_cs_s & r_cs_d;
   assign w_cs_rise   = r_cs_s & ~r_cs_d;
   assign w_push_data = {r_dc_s, r_shreg, r_sdi_s};

   // Synchronizer outputs hold reset values until refilled; SYNC waits for that
   always_ff @(posedge clk_125mhz or posedge reset) begin
      if (reset) begin
         r_settle <= 2'd0;
      end else if (r_settle != 2'd2) begin
         r_settle <= r_settle + 2'd1;
      end
   end

   always_ff @(posedge clk_125mhz or posedge reset) begin
      if (reset) begin
         r_state  <= S_SYNC;
         r_bitcnt <= '0;
         r_shreg  <= '0;
      end else begin
         r_state  <= w_state_nxt;
         r_bitcnt <= w_bitcnt_nxt;
         r_shreg  <= w_shreg_nxt;
      end
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_bitcnt_nxt = r_bitcnt;
      w_shreg_nxt  = r_shreg;
      w_push       = 1'b0;
      w_ferr_set   = 1'b0;
      case (r_state)
         S_SYNC: begin
            if (r_settle == 2'd2 && r_cs_s) w_state_nxt = S_IDLE;
         end
         S_IDLE: begin
            if (w_cs_fall) begin
               w_state_nxt  = S_SHIFT;
               w_bitcnt_nxt = '0;
               w_shreg_nxt  = '0;
            end
         end
         S_SHIFT: begin
            if (w_cs_rise) begin
               w_ferr_set   = 1'b1;
               w_state_nxt  = S_IDLE;
               w_bitcnt_nxt = '0;
               w_shreg_nxt  = '0;
            end else if (w_sck_rise) begin
               w_shreg_nxt  = {r_shreg[5:0], r_sdi_s};
               w_bitcnt_nxt = r_bitcnt + BW'(1);
               if (r_bitcnt == BW'(7)) begin
                  w_push      = 1'b1;
                  w_state_nxt = S_HOLD;
               end
            end
         end
         S_HOLD: begin
            if (w_sck_rise) w_ferr_set = 1'b1;
            if (w_cs_rise)  w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_SYNC;
      endcase
   end

   assign w_full    = (r_count == CW'(DEPTH));
   assign w_empty   = (r_count == '0);
   assign w_do_pop  = rd & ~w_empty;
   assign w_do_push = w_push & (~w_full | w_do_pop);
   assign w_ovf_set = w_push & w_full & ~w_do_pop;

   // When full, a simultaneous pop frees the head slot that wr_ptr points at
   always_ff @(posedge clk_125mhz or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) begin
            r_mem[r_wr_ptr] <= w_push_data;
            r_wr_ptr        <= r_wr_ptr + AW'(1);
         end
         if (w_do_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Sticky flags: a set event beats a simultaneous clear
   always_ff @(posedge clk_125mhz or posedge reset) begin
      if (reset) begin
         r_overflow  <= 1'b0;
         r_frame_err <= 1'b0;
      end else begin
         r_overflow  <= w_ovf_set  | (r_overflow  & ~clr);
         r_frame_err <= w_ferr_set | (r_frame_err & ~clr);
      end
   end

   assign rdata     = r_mem[r_rd_ptr];
   assign empty     = w_empty;
   assign full      = w_full;
   assign count     = r_count;
   assign overflow  = r_overflow;
   assign frame_err = r_frame_err;

endmodule

// File: tb/tb_spi_rx.sv
// Scoreboard bench for spi_rx: frames are bit-banged on the SPI pins, expected
// FIFO entries are queued as frames complete and compared as they are popped.
module tb_spi_rx;

   localparam int unsigned DEPTH = 4;

   logic                   clk_125mhz = 1'b0;
   logic                   reset;
   logic                   spi_cs_n, spi_sck, spi_sdi, spi_dc;
   logic                   rd, clr;
   logic [8:0]             rdata;
   logic                   empty, full, overflow, frame_err;
   logic [$clog2(DEPTH):0] count;

   logic [8:0] sb_q [$];
   logic       exp_ovf;
   logic       exp_ferr;
   int         n_chk;
   int         n_err;

   spi_rx #(.DEPTH(DEPTH)) u_dut (
      .clk_125mhz (clk_125mhz),
      .reset      (reset),
      .spi_cs_n   (spi_cs_n),
      .spi_sck    (spi_sck),
      .spi_sdi    (spi_sdi),
      .spi_dc     (spi_dc),
      .rd         (rd),
      .clr        (clr),
      .rdata      (rdata),
      .empty      (empty),
      .full       (full),
      .count      (count),
      .overflow   (overflow),
      .frame_err  (frame_err)
   );

   always #4 clk_125mhz = ~clk_125mhz;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk_125mhz);
   endtask

   task automatic chk_status(input string tag);
      chk({tag, ".count"},    32'(count),     32'(sb_q.size()));
      chk({tag, ".empty"},    32'(empty),     32'(sb_q.size() == 0));
      chk({tag, ".full"},     32'(full),      32'(sb_q.size() == DEPTH));
      chk({tag, ".overflow"}, 32'(overflow),  32'(exp_ovf));
      chk({tag, ".ferr"},     32'(frame_err), 32'(exp_ferr));
   endtask

   // Model of a completed byte arriving; rd_same means a pop in the same cycle
   task automatic sb_push(input logic [8:0] v, input bit rd_same);
      if (rd_same && sb_q.size() != 0) void'(sb_q.pop_front());
      if (sb_q.size() < DEPTH) sb_q.push_back(v);
      else exp_ovf = 1'b1;
   endtask

   // Send nbits MSB-first from bits; optional rd pulse aligned with the 8th-bit action
   task automatic send_frame(input logic [15:0] bits, input int nbits, input logic dc,
                             input bit rd_on_8th, input bit lat_chk);
      logic [7:0] byte_v;
      byte_v   = 8'h00;
      spi_dc   = dc;
      spi_cs_n = 1'b0;
      wait_clk(10);
      for (int i = 0; i < nbits; i++) begin
         spi_sck = 1'b0;
         spi_sdi = bits[nbits-1-i];
         if (i < 8) byte_v = {byte_v[6:0], bits[nbits-1-i]};
         wait_clk(25);
         spi_sck = 1'b1;
         if (i == 7) begin
            wait_clk(2);
            if (lat_chk) chk("latency.empty_before", 32'(empty), 32'd1);
            if (rd_on_8th) rd = 1'b1;
            wait_clk(1);
            rd = 1'b0;
            wait_clk(1);
            if (lat_chk) chk("latency.empty_after", 32'(empty), 32'd0);
            sb_push({dc, byte_v}, rd_on_8th);
            wait_clk(21);
         end else begin
            wait_clk(25);
         end
      end
      wait_clk(10);
      spi_cs_n = 1'b1;
      if (nbits != 8) exp_ferr = 1'b1;
      wait_clk(10);
   endtask

   task automatic pop_chk(input string tag);
      logic [8:0] exp_v;
      if (sb_q.size() == 0) begin
         chk({tag, ".empty"}, 32'(empty), 32'd1);
      end else begin
         exp_v = sb_q.pop_front();
         chk({tag, ".rdata"}, 32'(rdata), 32'(exp_v));
         rd = 1'b1;
         wait_clk(1);
         rd = 1'b0;
         wait_clk(1);
         chk({tag, ".count"}, 32'(count), 32'(sb_q.size()));
      end
   endtask

   task automatic pulse_clr();
      clr = 1'b1;
      wait_clk(1);
      clr = 1'b0;
      exp_ovf  = 1'b0;
      exp_ferr = 1'b0;
      wait_clk(1);
   endtask

   initial begin
      n_chk    = 0;
      n_err    = 0;
      exp_ovf  = 1'b0;
      exp_ferr = 1'b0;
      reset    = 1'b1;
      spi_cs_n = 1'b1;
      spi_sck  = 1'b1;
      spi_sdi  = 1'b0;
      spi_dc   = 1'b0;
      rd       = 1'b0;
      clr      = 1'b0;
      wait_clk(5);
      chk("reset.rdata", 32'(rdata), 32'h0);
      chk_status("reset");
      reset = 1'b0;
      wait_clk(10);

      // Single frame with latency check
      send_frame(16'h00A5, 8, 1'b1, 1'b0, 1'b1);
      chk_status("single");
      chk("single.rdata", 32'(rdata), 32'h1A5);
      pop_chk("single.pop");
      chk_status("single.after");

      // Fill past capacity; 5th frame dropped
      for (int k = 1; k <= 5; k++) begin
         send_frame(16'(k), 8, 1'b0, 1'b0, 1'b0);
         if (k == 4) chk_status("fill4");
      end
      chk_status("fill5");
      chk("fill.head", 32'(rdata), 32'h001);
      for (int k = 0; k < 4; k++) pop_chk("fill.pop");
      chk_status("fill.drained");
      pulse_clr();
      chk_status("fill.clr");

      // Short frame
      send_frame(16'h0015, 5, 1'b1, 1'b0, 1'b0);
      chk_status("short");
      pulse_clr();
      send_frame(16'h003C, 8, 1'b0, 1'b0, 1'b0);
      chk("short.next", 32'(rdata), 32'h03C);
      pop_chk("short.pop");

      // Long frame: 0x96 followed by a 1
      send_frame(16'h012D, 9, 1'b1, 1'b0, 1'b0);
      chk_status("long");
      pop_chk("long.pop");
      pulse_clr();

      // Full boundary: pop on the same cycle as the 8th-bit push
      for (int k = 0; k < 4; k++) send_frame(16'(8'h10 + k), 8, 1'b1, 1'b0, 1'b0);
      chk_status("bnd.full");
      send_frame(16'h0077, 8, 1'b0, 1'b1, 1'b0);
      chk_status("bnd.after");
      for (int k = 0; k < 4; k++) pop_chk("bnd.pop");
      chk_status("bnd.drained");

      // Reset mid-frame
      spi_cs_n = 1'b0;
      spi_dc   = 1'b1;
      wait_clk(10);
      for (int i = 0; i < 3; i++) begin
         spi_sck = 1'b0; spi_sdi = 1'b1; wait_clk(25);
         spi_sck = 1'b1; wait_clk(25);
      end
      reset = 1'b1;
      wait_clk(3);
      reset = 1'b0;
      sb_q.delete();
      exp_ovf  = 1'b0;
      exp_ferr = 1'b0;
      for (int i = 0; i < 5; i++) begin
         spi_sck = 1'b0; spi_sdi = 1'b0; wait_clk(25);
         spi_sck = 1'b1; wait_clk(25);
      end
      wait_clk(5);
      chk_status("rstmid.held");
      spi_cs_n = 1'b1;
      wait_clk(10);
      chk_status("rstmid.cs_high");
      send_frame(16'h00C3, 8, 1'b1, 1'b0, 1'b0);
      chk_status("rstmid.frame");
      chk("rstmid.rdata", 32'(rdata), 32'h1C3);
      pop_chk("rstmid.pop");

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/spi_rx.md
# spi_rx

SPI 8-bit input receiver (SPI slave) clocked at 125 MHz: the receiving end of the board's SPI output driver protocol. It oversamples an external chip-select, serial clock, data and data/command line, and assembles MSB-first bytes tagged with the D/C bit. Completed bytes go into a small show-ahead FIFO that the CPU bus side pops through a memory-mapped register wrapper.

## Interface
- DEPTH, 4: FIFO entries; power of two, 2..16.
- clk_125mhz  in  1  system clock.
- reset  in  1  reset, asynchronous, active-high; clock clk_125mhz.
- spi_cs_n  in  1  chip select, active-low, asynchronous to clk_125mhz.
- spi_sck  in  1  serial clock; idles high; sampled on rising edge.
- spi_sdi  in  1  serial data, MSB first.
- spi_dc  in  1  data/command tag; 1 = data, 0 = command.
- rd  in  1  single-cycle pop strobe.
- clr  in  1  single-cycle clear of the sticky flags.
- rdata  out  9  FIFO head entry {dc, byte[7:0]}; valid only while empty=0.
- empty  out  1  FIFO empty.
- full  out  1  FIFO full.
- count  out  $clog2(DEPTH)+1  number of occupied entries.
- overflow  out  1  sticky: a completed byte was dropped because the FIFO was full.
- frame_err  out  1  sticky: short frame (fewer than 8 bits) or long frame (more than 8 bits).

## Operation
- Synchronizers: two flops each for cs_n, sck, sdi and dc.
  - Reset values: cs_n=1, sck=1, sdi=0, dc=0.
  - A third register holds the previous synchronized cs_n and sck for edge detection.
- sck_rise = sck_s & ~sck_d.
- cs_fall and cs_rise are defined the same way.
- FSM states: SYNC (reset state), IDLE, SHIFT, HOLD.
- SYNC
  - Go to IDLE when cs_n_s = 1.
  - All sck edges are ignored, and no flags are set.
  - This keeps a reset released mid-frame from capturing a partial frame.
- IDLE
  - cs_fall goes to SHIFT, with bitcnt=0 and shreg=0.
  - sck edges are ignored.
- SHIFT
  - On sck_rise: shreg <= {shreg[6:0], sdi_s}, bitcnt <= bitcnt+1.
  - On the 8th sck_rise:
    - Push {dc_s, shreg[6:0], sdi_s} into the FIFO.
    - Go to HOLD.
  - cs_rise with bitcnt < 8: discard shreg, set frame_err, go to IDLE.
- HOLD
  - Any sck_rise sets frame_err. No data is captured.
  - cs_rise goes to IDLE.
- FIFO storage
  - Circular buffer with wrapping wr_ptr and rd_ptr, plus count.
  - rdata = mem[rd_ptr], driven combinationally (show-ahead).
  - All entries reset to 0, so rdata = 0 after reset.
- Push while full: the byte is dropped, overflow is set, and the FIFO is unchanged.
- Push and pop in the same cycle:
  - When full: both occur, count stays DEPTH, overflow is not set.
  - Otherwise: both occur, count is unchanged.
- rd while empty is ignored, and count never underflows.
  - If a push happens in that same cycle, only the push occurs.
- Sticky flags:
  - clr clears both flags.
  - A set event in the same cycle as clr wins, so the flag stays 1.
- Reset values: rdata=0, empty=1, full=0, count=0, overflow=0, frame_err=0, state=SYNC.
- Reset asserted mid-frame aborts everything and empties the FIFO.

## Timing
- Input-to-action latency is 3 clk_125mhz rising edges:
  - Edges 1 and 2: synchronizers. Edge detect is combinational on the synchronized signals.
  - Edge 3: state and FIFO update.
  - Example: empty falls after the 3rd clock edge following the first clock edge that samples the 8th spi_sck rise high.
- count, full and empty update on the same edge as the push or pop.
- After rd: rdata shows the next entry one cycle later.
- spi_sdi and spi_dc must be stable for at least 3 clk periods before, and 1 clk period after, each spi_sck rise.
  - The board driver (1.25 MHz SCK, data changed 400 ns before the rise) satisfies this with large margin.
- SCK high and low times must each be at least 4 clk periods (32 ns); the maximum supported SCK is 15.6 MHz.
- spi_cs_n must stay deasserted for at least 4 clk periods between frames.
- A cs_fall and an sck_rise detected in the same cycle: only the cs_fall is acted on; that sck edge is not counted.

## Test plan
- Single frame:
  - Stimulus: cs_n low, 8 bits of 0xA5 with dc=1, SCK period 50 clk, then cs_n high.
  - Response: empty 1→0, count=1, rdata=9'h1A5, flags 0; rd → empty=1, count=0.
- FIFO fill:
  - Stimulus: frames 0x01..0x05 with dc=0, no reads.
  - Response: full=1 after the 4th frame; 5th frame dropped; overflow=1; rdata=9'h001.
  - Four pops return 0x01..0x04 in order, then empty=1.
  - clr → overflow=0.
- Short frame:
  - Stimulus: cs_n low, 5 SCK rises, cs_n high.
  - Response: no push, frame_err=1.
  - A following 0x3C frame with dc=0 yields rdata=9'h03C.
- Long frame:
  - Stimulus: 9 SCK rises, bits 0x96 followed by 1.
  - Response: 9'h096 or 9'h196 (per dc) is pushed, frame_err=1, count=1.
- Full boundary:
  - Stimulus: FIFO full (4 entries); rd asserted on the exact cycle the 8th bit of 0x77 is detected.
  - Response: count stays 4, overflow=0, the old head is popped, 0x77 is the newest entry.
- Reset mid-frame:
  - Stimulus: reset pulsed after 3 bits while cs_n stays low; 5 further SCK rises; then cs_n high; then a full 0xC3 frame.
  - Response: nothing pushed and frame_err=0 before cs_n high; afterwards rdata shows 0xC3 with the frame's dc bit.
